// File: rtl/stream_muxn_pkg.sv
// stream_mux_pkg: shared types and default widths for the stream_muxn family.
//   mux_mode_e : selection mode (fixed channel select or round-robin)
//   DEF_N_CH   : default number of input channels
//   DEF_W      : default data width per channel
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

endpackage

// File: rtl/stream_muxn_if.sv
// stream_muxn_if: bundles the N input streams and the single output stream
// of stream_muxn.
//   in_valid/in_data/in_ready    : N producer channels, channel i at [i*W +: W]
//   out_valid/out_data/out_ch    : registered output beat and its source channel
//   out_ready                    : consumer accepts the output beat
//   modport slave  : the multiplexer's view
//   modport master : the producers'/consumer's view (drives inputs, observes outputs)
interface stream_muxn_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_muxn_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req : request vector (N bits)
//   ptr : index of the last granted channel; search starts at ptr+1
//   gnt : one-hot grant, zero when no request
//   idx : binary index of the granted channel (0 when no grant)
// Scheme: rotate req so ptr+1 lands at bit 0, isolate the lowest set bit,
// rotate the one-hot pick back to channel positions.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  logic [N-1:0]  pick;

  // ptr+1 modulo N without relying on N being a power of two
  always_comb begin
    start = (ptr >= IW'(N - 1)) ? '0 : ptr + IW'(1);
  end

  // Rotate right by start: rot[k] corresponds to channel (start+k) mod N
  assign rot  = N'({req, req} >> start);
  // Lowest set bit = first requester in the search order
  assign pick = rot & (~rot + N'(1));
  // Rotate left by start: upper copy of the doubled vector holds the wrap
  assign gnt  = N'(({pick, pick} << start) >> N);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/stream_muxn.sv
// stream_muxn: N-channel, W-bit valid/ready stream multiplexer with a
// registered output stage and fixed or round-robin channel selection.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   mode     : 0 = fixed (use sel), 1 = round-robin
//   sel      : channel used in fixed mode; values >= N_CH grant nothing
//   bus      : stream_muxn_if.slave carrying the input and output streams
// Throughput one beat per cycle, latency one cycle. in_ready is
// combinational; out_* come straight from flops.
module stream_muxn
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int W     = DEF_W,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_muxn_if.slave     bus
);

  mux_mode_e        mode_e;
  logic [N_CH-1:0]  rr_gnt;
  logic [N_CH-1:0]  fx_gnt;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic             load;
  logic             xfer;
  logic [W-1:0]     data_sel;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  assign mode_e = mux_mode_e'(mode);

  rr_arbiter #(.N(N_CH)) u_rr_arbiter (
    .req (bus.in_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Fixed-mode decode; an out-of-range sel matches no channel
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fixed
      assign fx_gnt[gi] = bus.in_valid[gi] & (sel == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    grant     = fx_gnt;
    grant_idx = sel;
    if (mode_e == MODE_RR) begin
      grant     = rr_gnt;
      grant_idx = rr_idx;
    end
  end

  assign load         = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = grant & {N_CH{load & ~rst}};
  assign xfer         = |(bus.in_valid & bus.in_ready);

  // AND-OR data select keyed on the one-hot grant
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      data_sel = data_sel | ({W{grant[i]}} & bus.in_data[i*W +: W]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = data_sel;
      out_ch_d    = grant_idx;
      // Fixed-mode transfers leave the round-robin position untouched
      if (mode_e == MODE_RR) ptr_d = grant_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
